// File: rtl/regfile_pkg.sv
// Shared register-file constants and types used by the datapath and regfile_dec.
package regfile_pkg;

  localparam int WIDTH_DEF  = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [WIDTH_DEF-1:0]  reg_data_t;

endpackage

// File: rtl/decoder_n.sv
// decoder_n: generic N_IN-to-2**N_IN one-hot decoder with enable.
// Purely combinational; no flow control.
module decoder_n
  import regfile_pkg::*;
#(
  parameter int N_IN = ADDR_W_DEF
) (
  input  logic [N_IN-1:0]      sel,
  input  logic                 en,
  output logic [2**N_IN-1:0]   out
);

  always_comb begin
    out = '0;
    if (en) out[sel] = 1'b1;
  end

endmodule

// File: rtl/regfile_dec.sv
// regfile_dec: 1W2R register file with one-hot write decode, optional zero reg and bypass.
// Read latency 0 (READ_REG=0) or 1 cycle; no backpressure, we is sampled on every edge.
module regfile_dec
  import regfile_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit READ_REG = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_W-1:0]     raddr_a,
  input  logic [ADDR_W-1:0]     raddr_b,
  output logic [WIDTH-1:0]      rdata_a,
  output logic [WIDTH-1:0]      rdata_b,
  output logic [2**ADDR_W-1:0]  wsel
);

  localparam int DEPTH = 2**ADDR_W;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [WIDTH-1:0] rdata_a_d;
  logic [WIDTH-1:0] rdata_b_d;
  logic             byp_en;

  decoder_n #(.N_IN(ADDR_W)) u_wdec (
    .sel (waddr),
    .en  (we),
    .out (wsel)
  );

  // wsel[0] still fires with ZERO_REG so the decoder stays observable; storage masks it.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      if (wsel[i] && !(ZERO_REG && i == 0)) regs_d[i] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Bypass is blocked in reset so combinational reads stay at 0 while rst_n is low.
  assign byp_en = BYPASS && we && rst_n;

  always_comb begin
    rdata_a_d = regs_q[raddr_a];
    if (byp_en && raddr_a == waddr) rdata_a_d = wdata;
    if (ZERO_REG && raddr_a == '0)  rdata_a_d = '0;

    rdata_b_d = regs_q[raddr_b];
    if (byp_en && raddr_b == waddr) rdata_b_d = wdata;
    if (ZERO_REG && raddr_b == '0)  rdata_b_d = '0;
  end

  if (READ_REG) begin : g_rd_reg
    logic [WIDTH-1:0] rdata_a_q;
    logic [WIDTH-1:0] rdata_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_a_q <= '0;
        rdata_b_q <= '0;
      end else begin
        rdata_a_q <= rdata_a_d;
        rdata_b_q <= rdata_b_d;
      end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
  end else begin : g_rd_comb
    assign rdata_a = rdata_a_d;
    assign rdata_b = rdata_b_d;
  end

endmodule

// File: tb/tb_regfile_dec.sv
// Bench for regfile_dec: three parameter sets driven in parallel against a behavioural array model.
module tb_regfile_dec;

  // Instance k: ZERO_REG = ZR[k], BYPASS = BY[k], READ_REG = RR[k]
  localparam bit [2:0] ZR = 3'b001;
  localparam bit [2:0] BY = 3'b101;
  localparam bit [2:0] RR = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [2:0][31:0] rda;
  logic [2:0][31:0] rdb;
  logic [2:0][31:0] wsl;

  logic [31:0] mem  [3][32];
  logic [31:0] rq_a [3];
  logic [31:0] rq_b [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_dec #(.ZERO_REG(1'b1), .BYPASS(1'b1), .READ_REG(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda[0]), .rdata_b(rdb[0]), .wsel(wsl[0]));

  regfile_dec #(.ZERO_REG(1'b0), .BYPASS(1'b0), .READ_REG(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda[1]), .rdata_b(rdb[1]), .wsel(wsl[1]));

  regfile_dec #(.ZERO_REG(1'b0), .BYPASS(1'b1), .READ_REG(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rda[2]), .rdata_b(rdb[2]), .wsel(wsl[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_read(input int k, input logic [4:0] a);
    if (ZR[k] && a == 5'd0) return 32'h0;
    if (BY[k] && rst_n && we && a == waddr) return wdata;
    return mem[k][a];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 32; i++) mem[k][i] = 32'h0;
      rq_a[k] = 32'h0;
      rq_b[k] = 32'h0;
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] ea, eb, ew;
    ew = we ? (32'h1 << waddr) : 32'h0;
    for (int k = 0; k < 3; k++) begin
      ea = RR[k] ? rq_a[k] : exp_read(k, raddr_a);
      eb = RR[k] ? rq_b[k] : exp_read(k, raddr_b);
      chk($sformatf("%s_rda%0d_a%0d", tag, k, raddr_a), rda[k], ea);
      chk($sformatf("%s_rdb%0d_a%0d", tag, k, raddr_b), rdb[k], eb);
      chk($sformatf("%s_wsel%0d", tag, k), wsl[k], ew);
    end
  endtask

  // Advance one rising edge and apply it to the model; leaves time #1 past the edge.
  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst_n) begin
        rq_a[k] = exp_read(k, raddr_a);
        rq_b[k] = exp_read(k, raddr_b);
        if (we && !(ZR[k] && waddr == 5'd0)) mem[k][waddr] = wdata;
      end
    end
    #1;
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] ra, input logic [4:0] rb);
    we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
    #2;
  endtask

  initial begin
    model_clear();
    rst_n = 1'b0;
    drive(1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd3);
    check_all("rst0");
    tick(); #2; check_all("rst1");
    tick(); #2; check_all("rst2");
    rst_n = 1'b1;
    drive(1'b0, 5'd3, 32'h0, 5'd3, 5'd0);
    check_all("post_rst");
    tick(); #2; check_all("post_rst_q");

    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 5'(i), $urandom, 5'($urandom_range(0, 31)), 5'(i));
      check_all("sweep");
      tick();
    end
    drive(1'b0, 5'd9, 32'h12345678, 5'd9, 5'd1);
    check_all("sweep_off");
    tick();

    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 5'(i), 32'h1000_0000 + i, 5'd0, 5'd0);
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      check_all("pair");
      tick(); #2;
      check_all("pair_q");
    end

    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    check_all("zero_w");
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check_all("zero_r");
    tick(); #2; check_all("zero_rq");

    drive(1'b1, 5'd7, 32'h11, 5'd1, 5'd2);
    tick();
    drive(1'b1, 5'd7, 32'h22, 5'd7, 5'd7);
    check_all("byp0");
    tick(); #2; check_all("byp0_q");
    drive(1'b0, 5'd7, 32'h0, 5'd7, 5'd7);
    check_all("byp1");
    tick(); #2; check_all("byp1_q");

    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd6);
    tick(); #2; check_all("rr5");
    drive(1'b0, 5'd0, 32'h0, 5'd6, 5'd6);
    check_all("rr6_pre");
    tick(); #2; check_all("rr6_post");

    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
            5'($urandom), 5'($urandom));
      if ($urandom_range(0, 3) == 0) raddr_b = waddr;
      #1;
      check_all("rnd");
      tick(); #2;
      check_all("rnd_q");
    end

    // Asynchronous reset in the middle of a write, between edges
    drive(1'b1, 5'd12, 32'hCAFEF00D, 5'd12, 5'd7);
    rst_n = 1'b0;
    model_clear();
    #1;
    check_all("arst_now");
    tick(); #2; check_all("arst_edge");
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      check_all("arst_rd");
      tick(); #2;
      check_all("arst_rd_q");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dec.md
# regfile_dec

Parametrised register file built around a generic one-hot write decoder: `DEPTH = 2**ADDR_W` registers of `WIDTH` bits, one write port and two read ports. It generalises the fixed 32-output decoder into a reusable `decoder_n`. It adds several features the decoder alone does not have: stored state, asynchronous clear, an optional hardwired-zero register, write-to-read bypass and an optional registered read stage. It sits between the datapath's writeback stage and operand fetch.

## Interface
- `WIDTH`, 32, data width of each register
- `ADDR_W`, 5, address width; `DEPTH = 2**ADDR_W`
- `ZERO_REG`, 1, 1 = register 0 reads as 0 and ignores writes
- `BYPASS`, 1, 1 = a read of the address being written this cycle returns `wdata`
- `READ_REG`, 0, 0 = combinational read; 1 = read data registered (1-cycle latency)
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `we`  in  1  write enable
- `waddr`  in  ADDR_W  write address
- `wdata`  in  WIDTH  write data
- `raddr_a`, `raddr_b`  in  ADDR_W  read addresses
- `rdata_a`, `rdata_b`  out  WIDTH  read data
- `wsel`  out  DEPTH  one-hot decoded write select; all-zero when `we`=0

## Operation
- `wsel = we ? (1 << waddr) : 0`. This is produced by `decoder_n` and is combinational.
- Writes:
  - On a rising `clk`, every register `i` with `wsel[i]`=1 loads `wdata`.
  - At most one register changes per cycle.
  - If `ZERO_REG`=1, register 0 never changes. `wsel[0]` still asserts, so the decoder is observable.
- Read path, per port, with `x` = the port's address:
  - `ZERO_REG` && x==0: 0.
  - Else if `BYPASS` && `we` && x==`waddr`: `wdata`.
  - Else: stored register x.
- `READ_REG`=0: `rdata_*` is the read-path value, combinationally.
- `READ_REG`=1: `rdata_*` is the read-path value captured at the rising edge. The bypass uses the `we`/`waddr`/`wdata` present in that same cycle, so the captured value is post-write.
- Both ports may read the same address and return identical data.
- Read/write on the same address with `BYPASS`=0 and `READ_REG`=0 returns the old value until the edge.
- Addresses are always in range because `DEPTH = 2**ADDR_W`. There is no out-of-range case.

## Timing
- Reset:
  - `rst_n`=0 asynchronously clears all registers to 0.
  - When `READ_REG`=1 it also clears `rdata_a`/`rdata_b` to 0.
  - With `READ_REG`=0, `rdata_*` therefore reads 0 during reset.
  - `wsel` stays combinational and follows `we`/`waddr` even during reset. No write takes effect while `rst_n`=0.
- Reset asserted mid-write: the write is lost and the register is 0.
- Release is synchronised externally. The first write may occur on the first rising edge with `rst_n`=1.
- Write latency: 1 edge, so data is visible through the non-bypass path from the next cycle.
- Read latency: 0 cycles (`READ_REG`=0) or 1 cycle (`READ_REG`=1).
- No handshake: `we` is sampled every edge. Back-to-back writes to any addresses are allowed.
- Simultaneous write to address k plus reads of k on both ports:
  - `BYPASS`=1: both ports see `wdata` in the same cycle.
  - `BYPASS`=0: both ports see the old value.

## Structure
- Package `regfile_pkg`: default `WIDTH`/`ADDR_W` constants and a `reg_addr_t` typedef. The datapath shares these.
- Sub-module `decoder_n`:
  - Parameter `N_IN`; ports `sel`[N_IN], `en`, `out`[2**N_IN].
  - Purely combinational; replaces the fixed-width decoder and is reused elsewhere.
  - Instantiated once for the write port.
- Storage is a flat register array with per-entry enable from `wsel`. Read muxing is inline.
- Target size is ~150–250 lines across both modules.

## Test plan
- Reset: `rst_n`=0 for 2 cycles with `we`=1, `waddr`=3, `wdata`=0xDEADBEEF. Release, then read addr 3 -> `rdata_a`=0. When `READ_REG`=1, `rdata_*`=0 throughout reset.
- Decoder sweep: `we`=1 with `waddr`=0..31 -> `wsel`=1<<waddr exactly one-hot; `we`=0 -> `wsel`=0.
- Write/readback: write 0x1000_0000+i to every i=1..31, then read all pairs (i, 31-i) -> correct values on both ports. Addr 0 reads 0 with `ZERO_REG`=1.
- Zero register: write 0xFFFFFFFF to addr 0 -> reads 0 when `ZERO_REG`=1, and 0xFFFFFFFF when `ZERO_REG`=0.
- Bypass:
  - Addr 7 holds 0x11; same cycle `we`=1, `waddr`=7, `wdata`=0x22, `raddr_a`=`raddr_b`=7.
  - `BYPASS`=1 -> 0x22 on both ports.
  - `BYPASS`=0 -> 0x11, then 0x22 the next cycle.
- Registered read and mid-op reset:
  - With `READ_REG`=1, change `raddr_a` 5->6 -> `rdata_a` updates one edge later.
  - Assert `rst_n` between edges -> `rdata_*` and all registers read 0 immediately, without waiting for a clock edge.
